add_sequencer: RTL

ADD_SEQUENCER -- requirements
Module: add_sequencer

---
 rtl/add_seq_pkg.sv | 13 +
 rtl/add_sequencer_ripple.sv | 26 ++
 rtl/add_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/add_seq_pkg.sv
// Shared types and default sizing for the slice-serial add sequencer.
package add_seq_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_SLICE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/add_sequencer_ripple.sv
// Gate-level ripple-carry adder; the sequencer reuses one instance per slice.
module add_sequencer_ripple #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             ci_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             co_o
);

    logic [WIDTH:0] carry_s;

    // Bitwise full-adder chain from LSB to MSB.
    always_comb begin
        carry_s    = '0;
        sum_o      = '0;
        carry_s[0] = ci_i;
        for (int i = 0; i < WIDTH; i++) begin
            sum_o[i]       = a_i[i] ^ b_i[i] ^ carry_s[i];
            carry_s[i + 1] = (a_i[i] & b_i[i]) | (a_i[i] & carry_s[i]) | (b_i[i] & carry_s[i]);
        end
        co_o = carry_s[WIDTH];
    end

endmodule

// File: rtl/add_sequencer.sv
// Slice-serial adder: SLICE bits per cycle, N = WIDTH/SLICE cycles per operation.
// Optional subtract mode is enabled by defining ADD_SEQUENCER_SUB_EN.
module add_sequencer
    import add_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SLICE = DEFAULT_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef ADD_SEQUENCER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             busy
);

    localparam int N = WIDTH / SLICE;
    // The slice index is kept one-hot so stepping it needs no adder; bit 0 set means idx 0.
    localparam logic [N-1:0] IDX_FIRST = N'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic [N-1:0]     idx_q, idx_d;

    logic [SLICE-1:0] a_slice_s;
    logic [SLICE-1:0] b_slice_s;
    logic [SLICE-1:0] slice_sum_s;
    logic             slice_co_s;
    logic [WIDTH-1:0] b_capture_s;
    logic             c_capture_s;

    // Operand conditioning at acceptance: subtraction is a + ~b + 1.
    always_comb begin
`ifdef ADD_SEQUENCER_SUB_EN
        if (sub) begin
            b_capture_s = ~b;
            c_capture_s = 1'b1;
        end else begin
            b_capture_s = b;
            c_capture_s = ci;
        end
`else
        b_capture_s = b;
        c_capture_s = ci;
`endif
    end

    // One-hot mux picking the active slice of each captured operand.
    always_comb begin
        a_slice_s = '0;
        b_slice_s = '0;
        for (int i = 0; i < N; i++) begin
            a_slice_s = a_slice_s | (a_q[i*SLICE +: SLICE] & {SLICE{idx_q[i]}});
            b_slice_s = b_slice_s | (b_q[i*SLICE +: SLICE] & {SLICE{idx_q[i]}});
        end
    end

    add_sequencer_ripple #(
        .WIDTH (SLICE)
    ) u_slice_adder (
        .a_i   (a_slice_s),
        .b_i   (b_slice_s),
        .ci_i  (c_q),
        .sum_o (slice_sum_s),
        .co_o  (slice_co_s)
    );

    // Next-state logic for the IDLE/RUN/DONE sequencer and its datapath registers.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_d     = c_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b_capture_s;
                    c_d     = c_capture_s;
                    idx_d   = IDX_FIRST;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int i = 0; i < N; i++) begin
                    sum_d[i*SLICE +: SLICE] = idx_q[i] ? slice_sum_s : sum_q[i*SLICE +: SLICE];
                end
                c_d   = slice_co_s;
                idx_d = (idx_q << 1) | (idx_q >> (N - 1));
                if (idx_q[N-1]) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            idx_q   <= IDX_FIRST;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign sum       = sum_q;
    assign co        = c_q;

endmodule
